// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions used by the block responder and the
// cache's memory side: bus widths, FSM encodings and the latency preload.
package mem_if_pkg;

    localparam int ADDR_W          = 28;
    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;
    localparam int CNT_W           = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } mem_state_t;

    // Counter value loaded on acceptance: the remaining BUSY cycles before RESP.
    function automatic logic [CNT_W-1:0] latency_preload(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_block_array.sv
// Single-port block storage: 2**IDX_W entries of BLOCK_W bits, built as one
// word-wide lane per 32-bit word so each lane maps onto its own block RAM.
// Read data is registered; a write cycle leaves the read register unchanged.
module mem_block_array
    import mem_if_pkg::*;
#(
    parameter int IDX_W   = 10,
    parameter int BLK_W   = mem_if_pkg::BLOCK_W,
    parameter int LANE_W  = mem_if_pkg::WORD_W
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [IDX_W-1:0]   addr,
    input  logic [BLK_W-1:0]   wdata,
    output logic [BLK_W-1:0]   rdata
);

    localparam int LANES = BLK_W / LANE_W;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] lane_mem [2**IDX_W];
            logic [LANE_W-1:0] lane_q;

            // Lane access: write when enabled with we, otherwise registered read.
            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        lane_mem[addr] <= wdata[gi*LANE_W +: LANE_W];
                    end else begin
                        lane_q <= lane_mem[addr];
                    end
                end
            end

            assign rdata[gi*LANE_W +: LANE_W] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/mem_block_responder.sv
// Main-memory model behind the cache: accepts one-block read or write-back
// requests, waits LATENCY cycles and answers with a single-cycle mem_ready.
// Protocol slips (read+write together, request dropped or address moved
// while waiting) raise a sticky proto_err that only reset clears.
module mem_block_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = mem_if_pkg::ADDR_W,
    parameter int BLOCK_W = mem_if_pkg::BLOCK_W,
    parameter int IDX_W   = 10,
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic [BLOCK_W-1:0] mem_wdata,
    output logic [BLOCK_W-1:0] mem_rdata,
    output logic               mem_ready,
    output logic               proto_err
);

    mem_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               op_write_reg, op_write_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic [BLOCK_W-1:0] wdata_reg;
    logic [BLOCK_W-1:0] rdata_reg;
    logic               proto_err_reg;

    logic               accept;
    logic               abort_req;
    logic               both_req;

    logic               arr_en;
    logic               arr_we;
    logic               rd_fire;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   arr_addr;
    logic [BLOCK_W-1:0] arr_rdata;

    // Next-state and counter logic; an abort always wins over reaching RESP.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        op_write_next = op_write_reg;
        accept        = 1'b0;
        abort_req     = 1'b0;
        both_req      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_read || mem_write) begin
                    accept        = 1'b1;
                    op_write_next = mem_write;
                    both_req      = mem_read && mem_write;
                    count_next    = latency_preload(LATENCY);
                    state_next    = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if ((!mem_read && !mem_write) || (mem_addr != addr_reg)) begin
                    abort_req  = 1'b1;
                    count_next = '0;
                    state_next = IDLE;
                end else if (count_reg == CNT_W'(1)) begin
                    count_next = '0;
                    state_next = RESP;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Array port control: the read is launched on the edge entering RESP so
    // data is ready during RESP; the write commits on the edge leaving RESP.
    // Both are suppressed while reset is asserted.
    always_comb begin
        rd_fire  = (state_next == RESP) && !op_write_next && !rst;
        arr_we   = (state_reg == RESP) && op_write_reg && !rst;
        rd_idx   = (state_reg == IDLE) ? mem_addr[IDX_W-1:0] : addr_reg[IDX_W-1:0];
        arr_addr = arr_we ? addr_reg[IDX_W-1:0] : rd_idx;
        arr_en   = arr_we || rd_fire;
    end

    // FSM state, counter and latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            op_write_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            op_write_reg <= op_write_next;
            if (accept) begin
                addr_reg  <= mem_addr;
                wdata_reg <= mem_wdata;
            end
        end
    end

    // Sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_reg <= 1'b0;
        end else if (both_req || abort_req) begin
            proto_err_reg <= 1'b1;
        end
    end

    // Resettable copy of the last returned block, so mem_rdata holds (and is
    // never X) outside RESP even though the RAM output register has no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (state_reg == RESP && !op_write_reg) begin
            rdata_reg <= arr_rdata;
        end
    end

    mem_block_array #(
        .IDX_W  (IDX_W),
        .BLK_W  (BLOCK_W),
        .LANE_W (WORD_W)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (wdata_reg),
        .rdata (arr_rdata)
    );

    assign mem_ready = (state_reg == RESP);
    assign mem_rdata = (state_reg == RESP && !op_write_reg) ? arr_rdata : rdata_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_mem_block_responder.sv
// Bench for mem_block_responder: a LATENCY=4 instance (index 0) and a
// LATENCY=1 instance (index 1). Expected completions are queued when a
// request is driven and popped when mem_ready appears; data comes from a
// reference block memory kept by the bench.
`timescale 1ns/1ps
module tb_mem_block_responder;
    import mem_if_pkg::*;

    localparam int AW = 28;
    localparam int BW = 128;
    localparam int IW = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          rd, wr, ready, perr;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][BW-1:0]  wdata, rdata;

    int cyc    = 0;
    int checks = 0;
    int passes = 0;

    typedef struct {
        int          inst;
        logic        is_read;
        logic [BW-1:0] data;
        int          due;
    } exp_t;

    exp_t          sb[$];
    logic [BW-1:0] model [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_block_responder #(.ADDR_W(AW), .BLOCK_W(BW), .IDX_W(IW), .LATENCY(4)) u_dut0 (
        .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
        .mem_ready(ready[0]), .proto_err(perr[0])
    );

    mem_block_responder #(.ADDR_W(AW), .BLOCK_W(BW), .IDX_W(IW), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
        .mem_ready(ready[1]), .proto_err(perr[1])
    );

    // Drive one request at the current negedge, queue its expected result,
    // wait for mem_ready and compare; leaves the bench one negedge after RESP.
    task automatic do_req(input int inst, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [BW-1:0] d,
                          input int lat, output int ready_cyc);
        exp_t e;
        int   key;
        bit   seen;
        key       = inst * 1024 + int'(a[IW-1:0]);
        e.inst    = inst;
        e.due     = cyc + lat;
        e.is_read = r && !w;
        if (w) begin
            model[key] = d;
            e.data     = d;
        end else begin
            e.data = model.exists(key) ? model[key] : '0;
        end
        sb.push_back(e);
        rd[inst] = r; wr[inst] = w; addr[inst] = a; wdata[inst] = d;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (ready[inst] === 1'b1) seen = 1'b1;
        end
        ready_cyc = cyc;
        e = sb.pop_front();
        checks++;
        if (!seen)
            $display("FAIL ready_timeout inst%0d addr=%h: no mem_ready, required at cycle %0d", inst, a, e.due);
        else if (cyc != e.due)
            $display("FAIL ready_cycle inst%0d addr=%h: got cycle %0d, required %0d", inst, a, cyc, e.due);
        else passes++;
        if (e.is_read) begin
            checks++;
            if (rdata[inst] !== e.data)
                $display("FAIL read_data inst%0d addr=%h: got %h, required %h", inst, a, rdata[inst], e.data);
            else passes++;
        end
        $display("txn inst%0d %s addr=%h data=%h ready@%0d", inst, e.is_read ? "RD" : "WR", a,
                 e.is_read ? rdata[inst] : d, cyc);
        rd[inst] = 1'b0; wr[inst] = 1'b0;
        @(negedge clk);
        checks++;
        if (ready[inst] !== 1'b0)
            $display("FAIL ready_width inst%0d: mem_ready still %b one cycle after pulse, required 0", inst, ready[inst]);
        else passes++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        rd = '0; wr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd = '0; wr = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ready[k] !== 1'b0) $display("FAIL reset_ready inst%0d: got %b, required 0", k, ready[k]); else passes++;
            checks++;
            if (rdata[k] !== '0) $display("FAIL reset_rdata inst%0d: got %h, required 0", k, rdata[k]); else passes++;
            checks++;
            if (perr[k] !== 1'b0) $display("FAIL reset_proto_err inst%0d: got %b, required 0", k, perr[k]); else passes++;
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int rc;
        do_req(0, 1'b0, 1'b1, 28'h0000010, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 4, rc);
        do_req(0, 1'b1, 1'b0, 28'h0000010, '0, 4, rc);
    endtask

    // Write-back then refill of an aliasing address (same low IW bits).
    task automatic test_back_to_back();
        int t0, rc_w, rc_r;
        t0 = cyc;
        do_req(0, 1'b0, 1'b1, 28'h0000023, 128'h11112222_33334444_55556666_77778888, 4, rc_w);
        do_req(0, 1'b1, 1'b0, 28'h0000423, '0, 4, rc_r);
        checks++;
        if (rc_r - t0 != 9) $display("FAIL b2b_total inst0: refill ready %0d cycles after write-back request, required 9", rc_r - t0);
        else passes++;
        checks++;
        if (perr[0] !== 1'b0) $display("FAIL b2b_proto_err inst0: got %b, required 0", perr[0]); else passes++;
    endtask

    task automatic test_latency1();
        int rc, t0;
        for (int i = 0; i < 8; i++)
            do_req(1, 1'b0, 1'b1, AW'(i), {4{32'(32'h1111_1111 * (i + 1))}}, 1, rc);
        t0 = cyc;
        for (int i = 0; i < 8; i++)
            do_req(1, 1'b1, 1'b0, AW'(i), '0, 1, rc);
        checks++;
        if (cyc - t0 != 16) $display("FAIL lat1_cadence inst1: 8 reads took %0d cycles, required 16", cyc - t0);
        else passes++;
    endtask

    task automatic test_simultaneous();
        int rc;
        do_req(0, 1'b1, 1'b1, 28'h0000005, 128'h0BADF00D_5555AAAA_FEEDFACE_12345678, 4, rc);
        checks++;
        if (perr[0] !== 1'b1) $display("FAIL simul_proto_err inst0: got %b, required 1", perr[0]); else passes++;
        do_req(0, 1'b1, 1'b0, 28'h0000005, '0, 4, rc);
    endtask

    task automatic test_abort();
        int rc;
        bit pulsed;
        apply_reset();
        checks++;
        if (perr[0] !== 1'b0) $display("FAIL abort_pre_proto_err inst0: got %b, required 0", perr[0]); else passes++;
        rd[0] = 1'b1; addr[0] = 28'h0000010;
        repeat (2) @(negedge clk);
        rd[0] = 1'b0;
        pulsed = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ready[0] !== 1'b0) pulsed = 1'b1;
        end
        checks++;
        if (pulsed) $display("FAIL abort_ready inst0: got a mem_ready pulse, required none"); else passes++;
        checks++;
        if (perr[0] !== 1'b1) $display("FAIL abort_proto_err inst0: got %b, required 1", perr[0]); else passes++;
        checks++;
        if (u_dut0.state_reg !== IDLE) $display("FAIL abort_state inst0: got %b, required %b", u_dut0.state_reg, IDLE);
        else passes++;
        do_req(0, 1'b1, 1'b0, 28'h0000010, '0, 4, rc);
    endtask

    // Reset landing in BUSY, then in RESP, of a write to block 7.
    task automatic test_reset_mid();
        int rc;
        do_req(0, 1'b0, 1'b1, 28'h0000007, 128'h70707070_71717171_72727272_73737373, 4, rc);
        do_req(0, 1'b1, 1'b0, 28'h0000007, '0, 4, rc);
        for (int k = 0; k < 2; k++) begin
            int off;
            off = (k == 0) ? 2 : 4;
            wr[0] = 1'b1; addr[0] = 28'h0000007; wdata[0] = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
            repeat (off) @(negedge clk);
            checks++;
            if (ready[0] !== (k == 1)) $display("FAIL rstmid_pre_ready inst0 off=%0d: got %b, required %b", off, ready[0], k == 1);
            else passes++;
            rst = 1'b1; wr[0] = 1'b0;
            @(negedge clk);
            checks++;
            if (ready[0] !== 1'b0) $display("FAIL rstmid_ready inst0 off=%0d: got %b, required 0", off, ready[0]); else passes++;
            checks++;
            if (rdata[0] !== '0) $display("FAIL rstmid_rdata inst0 off=%0d: got %h, required 0", off, rdata[0]); else passes++;
            checks++;
            if (perr[0] !== 1'b0) $display("FAIL rstmid_proto_err inst0 off=%0d: got %b, required 0", off, perr[0]); else passes++;
            @(negedge clk);
            rst = 1'b0;
            do_req(0, 1'b1, 1'b0, 28'h0000007, '0, 4, rc);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_latency1();
        test_simultaneous();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
